// File: rtl/b2_demux_1_4_reg.sv
// Registered 1-to-4 demultiplexer: a debounced, active-low key strobe writes d into one of
// four held lanes, chosen by sel or by an auto-incrementing pointer.
module b2_demux_1_4_reg #(
  parameter int unsigned W         = 2,
  parameter int unsigned DB_CYCLES = 50000,
  parameter int unsigned CW        = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  input  logic [1:0]   sel,
  input  logic         auto_inc,
  input  logic         wr_key_n,
  input  logic         clr,
  output logic [W-1:0] q0,
  output logic [W-1:0] q1,
  output logic [W-1:0] q2,
  output logic [W-1:0] q3,
  output logic [3:0]   vld,
  output logic [1:0]   ptr,
  output logic         ovr
);

  logic          r_s1, r_s2;
  logic          r_db, r_db_d;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_q [4];
  logic [3:0]    r_vld;
  logic [1:0]    r_ptr;
  logic          r_ovr;

  logic          w_wr_stb;
  logic [1:0]    w_lane;

  // Key path: two-flop synchronizer, then a level must persist DB_CYCLES samples to be accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_db   <= 1'b1;
      r_db_d <= 1'b1;
      r_cnt  <= '0;
    end else begin
      r_s1   <= wr_key_n;
      r_s2   <= r_s1;
      r_db_d <= r_db;
      if (r_s2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
        r_db  <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Only the debounced falling edge (press) strobes.
  assign w_wr_stb = r_db_d & ~r_db;
  assign w_lane   = auto_inc ? r_ptr : sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_q[i] <= '0;
      r_vld <= '0;
      r_ptr <= '0;
      r_ovr <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < 4; i++) r_q[i] <= '0;
      r_vld <= '0;
      r_ptr <= '0;
      r_ovr <= 1'b0;
    end else if (w_wr_stb) begin
      r_q[w_lane]   <= d;
      r_vld[w_lane] <= 1'b1;
      r_ovr         <= r_ovr | r_vld[w_lane];
      if (auto_inc) r_ptr <= r_ptr + 2'd1;
    end
  end

  assign q0  = r_q[0];
  assign q1  = r_q[1];
  assign q2  = r_q[2];
  assign q3  = r_q[3];
  assign vld = r_vld;
  assign ptr = r_ptr;
  assign ovr = r_ovr;

endmodule

// File: tb/tb_b2_demux_1_4_reg.sv
// Bench for b2_demux_1_4_reg: directed scenarios plus random key/switch traffic, checked every
// cycle against a sample-window reference model.
module tb_b2_demux_1_4_reg;
  localparam int W  = 2;
  localparam int DB = 4;
  localparam int CW = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] d = '0;
  logic [1:0]   sel = '0;
  logic         auto_inc = 1'b0;
  logic         wr_key_n = 1'b1;
  logic         clr = 1'b0;
  logic [W-1:0] q0, q1, q2, q3;
  logic [3:0]   vld;
  logic [1:0]   ptr;
  logic         ovr;

  int total = 0;
  int bad   = 0;

  b2_demux_1_4_reg #(.W(W), .DB_CYCLES(DB), .CW(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .d        (d),
    .sel      (sel),
    .auto_inc (auto_inc),
    .wr_key_n (wr_key_n),
    .clr      (clr),
    .q0       (q0),
    .q1       (q1),
    .q2       (q2),
    .q3       (q3),
    .vld      (vld),
    .ptr      (ptr),
    .ovr      (ovr)
  );

  always #5 clk = ~clk;

  // Reference model: raw key samples per edge; the debouncer sees them two edges late, and
  // the accepted level flips once the last DB seen samples all disagree with it.
  bit           key_hist[$];
  bit           win[$];
  bit           m_db, m_pend;
  logic [W-1:0] m_q[4];
  logic [3:0]   m_vld;
  logic [1:0]   m_ptr;
  logic         m_ovr;

  function automatic void model_reset();
    key_hist.delete();
    win.delete();
    m_db   = 1'b1;
    m_pend = 1'b0;
    for (int i = 0; i < 4; i++) m_q[i] = '0;
    m_vld = '0;
    m_ptr = '0;
    m_ovr = 1'b0;
  endfunction

  function automatic void model_edge();
    bit seen;
    bit all_diff;
    int lane;
    seen = (key_hist.size() >= 2) ? key_hist[key_hist.size()-2] : 1'b1;
    key_hist.push_back(wr_key_n);
    if (clr) begin
      for (int i = 0; i < 4; i++) m_q[i] = '0;
      m_vld = '0;
      m_ptr = '0;
      m_ovr = 1'b0;
    end else if (m_pend) begin
      lane = auto_inc ? int'(m_ptr) : int'(sel);
      m_ovr = m_ovr | m_vld[lane];
      m_q[lane] = d;
      m_vld[lane] = 1'b1;
      if (auto_inc) m_ptr = m_ptr + 2'd1;
    end
    m_pend = 1'b0;
    win.push_back(seen);
    if (win.size() >= DB) begin
      all_diff = 1'b1;
      for (int i = win.size() - DB; i < win.size(); i++)
        if (win[i] == m_db) all_diff = 1'b0;
      if (all_diff) begin
        m_db = seen;
        win.delete();
        if (seen == 1'b0) m_pend = 1'b1;
      end
    end
    if (seen == m_db) win.delete();
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".q0"},  32'(q0),  32'(m_q[0]));
    check({tag, ".q1"},  32'(q1),  32'(m_q[1]));
    check({tag, ".q2"},  32'(q2),  32'(m_q[2]));
    check({tag, ".q3"},  32'(q3),  32'(m_q[3]));
    check({tag, ".vld"}, 32'(vld), 32'(m_vld));
    check({tag, ".ptr"}, 32'(ptr), 32'(m_ptr));
    check({tag, ".ovr"}, 32'(ovr), 32'(m_ovr));
  endtask

  // Inputs are changed 1 time unit after an edge and held through the next edge.
  task automatic tick(input string tag, input bit key);
    wr_key_n = key;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic press(input string tag, input int low, input int high);
    for (int i = 0; i < low; i++) tick(tag, 1'b0);
    for (int i = 0; i < high; i++) tick(tag, 1'b1);
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;
    tick("idle", 1'b1);

    // Basic write to lane 2; lands on the 7th edge after the first low sample
    sel = 2'd2; d = 2'b11; auto_inc = 1'b0;
    for (int i = 0; i < 6; i++) tick("t1", 1'b0);
    check("t1.q2_before", 32'(q2), 32'd0);
    tick("t1", 1'b0);
    check("t1.q2_at_e6", 32'(q2), 32'd3);
    press("t1", 5, 8);
    check("t1.vld", 32'(vld), 32'b0100);
    check("t1.ovr", 32'(ovr), 32'd0);

    // Bounce: only the final long low run is accepted
    sel = 2'd0; d = 2'b01;
    press("t2", 3, 1);
    press("t2", 2, 1);
    check("t2.no_glitch_write", 32'(vld), 32'b0100);
    press("t2", 12, 8);
    check("t2.vld", 32'(vld), 32'b0101);
    check("t2.ovr", 32'(ovr), 32'd0);

    // Auto-increment through all lanes then wrap and overwrite lane 0
    clr = 1'b1; tick("clr", 1'b1); clr = 1'b0;
    auto_inc = 1'b1;
    for (int k = 0; k < 5; k++) begin
      d = (k == 4) ? 2'd2 : 2'(k);
      press("t3", 8, 8);
    end
    check("t3.q0", 32'(q0), 32'd2);
    check("t3.q1", 32'(q1), 32'd1);
    check("t3.q2", 32'(q2), 32'd2);
    check("t3.q3", 32'(q3), 32'd3);
    check("t3.ptr", 32'(ptr), 32'd1);
    check("t3.ovr", 32'(ovr), 32'd1);
    check("t3.vld", 32'(vld), 32'b1111);

    // Clear coincident with the strobe cycle wins
    auto_inc = 1'b0; sel = 2'd1; d = 2'd3;
    for (int i = 0; i < 6; i++) tick("t4", 1'b0);
    clr = 1'b1;
    tick("t4", 1'b0);
    clr = 1'b0;
    press("t4", 5, 8);
    check("t4.q1", 32'(q1), 32'd0);
    check("t4.vld", 32'(vld), 32'd0);
    check("t4.ptr", 32'(ptr), 32'd0);
    check("t4.ovr", 32'(ovr), 32'd0);
    d = 2'd2;
    press("t4", 8, 8);
    check("t4.q1_next", 32'(q1), 32'd2);

    // Long hold then release: one write only, so lane 3 never overflows
    sel = 2'd3; d = 2'd1;
    press("t5", 100, 12);
    check("t5.vld", 32'(vld), 32'b1010);
    check("t5.q3", 32'(q3), 32'd1);
    check("t5.ovr", 32'(ovr), 32'd0);

    // Reset mid-debounce; write lands DB+2 edges after the first post-reset low sample
    sel = 2'd0; d = 2'd3;
    for (int i = 0; i < 3; i++) tick("t6", 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t6.async");
    repeat (2) @(posedge clk);
    #1;
    check_all("t6.held");
    rst_n = 1'b1;
    press("t6", 12, 8);
    check("t6.q0", 32'(q0), 32'd3);
    check("t6.vld", 32'(vld), 32'b0001);

    // Random key runs and switch settings
    for (int n = 0; n < 120; n++) begin
      d        = 2'($urandom_range(0, 3));
      sel      = 2'($urandom_range(0, 3));
      auto_inc = 1'($urandom_range(0, 1));
      clr      = ($urandom_range(0, 15) == 0);
      tick("rnd", 1'($urandom_range(0, 1)));
      clr = 1'b0;
      press("rnd", $urandom_range(1, 8), $urandom_range(1, 8));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
